// File: rtl/keccak_pkg.sv
// keccak_pkg: FSM state encoding and padding byte constants shared by the padder.
// Build option: define KECCAK_PADDER_SHA3_EN to select the SHA-3 domain-separation
// suffix (0x06). When it is left undefined, the original Keccak suffix (0x01) is used.
package keccak_pkg;

   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_PAD    = 2'd1,
      ST_FULL   = 2'd2
   } state_t;

`ifdef KECCAK_PADDER_SHA3_EN
   localparam logic [7:0] SUFFIX = 8'h06;
`else
   localparam logic [7:0] SUFFIX = 8'h01;
`endif

   // Final padding bit, sitting in the least-significant byte of the last rate word.
   localparam logic [7:0] FINAL_BIT = 8'h80;

endpackage

// File: rtl/keccak_pad_word.sv
// keccak_pad_word: combinational pad of the final, partial message word.
// Byte 0 is the most-significant byte. Bytes below i_byte_num pass through,
// byte i_byte_num becomes SUFFIX, and every byte after it is zero.
module keccak_pad_word
   import keccak_pkg::*;
#(
   parameter int WORD_W = 64
) (
   input  logic [WORD_W-1:0]           i_word,
   input  logic [$clog2(WORD_W/8)-1:0] i_byte_num,
   output logic [WORD_W-1:0]           o_word
);

   localparam int NB   = WORD_W / 8;
   localparam int BN_W = $clog2(NB);

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_byte
         assign o_word[WORD_W-1-8*gi -: 8] =
            (BN_W'(gi) < i_byte_num)  ? i_word[WORD_W-1-8*gi -: 8] :
            (BN_W'(gi) == i_byte_num) ? SUFFIX : 8'h00;
      end
   endgenerate

endmodule

// File: rtl/keccak_padder_param.sv
// keccak_padder_param: packs message words into rate blocks and applies Keccak
// multi-rate padding (suffix byte ... 0x80). Word 0 of a block sits in the top
// bits of `out`. The suffix byte is selected by KECCAK_PADDER_SHA3_EN (see keccak_pkg).
module keccak_padder_param
   import keccak_pkg::*;
#(
   parameter int WORD_W     = 64,
   parameter int RATE_WORDS = 9
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WORD_W-1:0]            in,
   input  logic                         in_valid,
   input  logic                         is_last,
   input  logic [$clog2(WORD_W/8)-1:0]  byte_num,
   output logic                         in_ready,
   output logic [RATE_WORDS*WORD_W-1:0] out,
   output logic                         buffer_full,
   output logic                         last_block,
   input  logic                         f_ack
);

   localparam int CNT_W = $clog2(RATE_WORDS + 1);
   localparam logic [WORD_W-1:0] FINAL_WORD = WORD_W'(FINAL_BIT);
   localparam logic [CNT_W-1:0]  LAST_SLOT  = CNT_W'(RATE_WORDS - 1);

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               r_last_block;
   logic               w_last_next;
   logic               w_we;
   logic               w_clear;
   logic [WORD_W-1:0]  w_wdata;
   logic [WORD_W-1:0]  w_pad_word;

   keccak_pad_word #(
      .WORD_W (WORD_W)
   ) u_pad_word (
      .i_word     (in),
      .i_byte_num (byte_num),
      .o_word     (w_pad_word)
   );

   // State, slot counter and last-block flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_ACCEPT;
         r_cnt        <= '0;
         r_last_block <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_last_block <= w_last_next;
      end
   end

   // Next state plus the slot write (enable/data) and block clear.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_last_next  = r_last_block;
      w_we         = 1'b0;
      w_clear      = 1'b0;
      w_wdata      = '0;
      case (r_state)
         ST_ACCEPT: begin
            if (in_valid) begin
               w_we       = 1'b1;
               w_cnt_next = r_cnt + CNT_W'(1);
               if (is_last) begin
                  if (r_cnt == LAST_SLOT) begin
                     // Suffix and final bit land in the same word.
                     w_wdata      = w_pad_word | FINAL_WORD;
                     w_state_next = ST_FULL;
                     w_last_next  = 1'b1;
                  end else begin
                     w_wdata      = w_pad_word;
                     w_state_next = ST_PAD;
                  end
               end else begin
                  w_wdata = in;
                  if (r_cnt == LAST_SLOT) begin
                     w_state_next = ST_FULL;
                     w_last_next  = 1'b0;
                  end
               end
            end
         end
         ST_PAD: begin
            // Zero fill, one slot per cycle; the final slot carries the 0x80 bit.
            w_we       = 1'b1;
            w_cnt_next = r_cnt + CNT_W'(1);
            if (r_cnt == LAST_SLOT) begin
               w_wdata      = FINAL_WORD;
               w_state_next = ST_FULL;
               w_last_next  = 1'b1;
            end else begin
               w_wdata = '0;
            end
         end
         ST_FULL: begin
            if (f_ack) begin
               w_clear      = 1'b1;
               w_cnt_next   = '0;
               w_last_next  = 1'b0;
               w_state_next = ST_ACCEPT;
            end
         end
         default: begin
            w_state_next = ST_ACCEPT;
            w_cnt_next   = '0;
            w_last_next  = 1'b0;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < RATE_WORDS; gi++) begin : g_slot
         logic [WORD_W-1:0] r_word;

         // Slot register: cleared on acknowledge, loaded when the counter points here.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_word <= '0;
            end else if (w_clear) begin
               r_word <= '0;
            end else if (w_we && (r_cnt == CNT_W'(gi))) begin
               r_word <= w_wdata;
            end
         end

         assign out[(RATE_WORDS-gi)*WORD_W-1 -: WORD_W] = r_word;
      end
   endgenerate

   assign in_ready    = (r_state == ST_ACCEPT);
   assign buffer_full = (r_state == ST_FULL);
   assign last_block  = r_last_block;

endmodule

// File: tb/tb_keccak_padder_param.sv
// tb_keccak_padder_param: randomized and directed stimulus, with the expected
// blocks computed from a byte-level model of Keccak padding.
module tb_keccak_padder_param;

   localparam int WORD_W     = 64;
   localparam int RATE_WORDS = 9;
   localparam int NB         = WORD_W / 8;
   localparam int BN_W       = $clog2(NB);
   localparam int OUT_W      = WORD_W * RATE_WORDS;
   localparam int RATE_BYTES = NB * RATE_WORDS;

`ifdef KECCAK_PADDER_SHA3_EN
   localparam logic [7:0] SUFFIX_B = 8'h06;
`else
   localparam logic [7:0] SUFFIX_B = 8'h01;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [WORD_W-1:0] in_w = '0;
   logic              in_valid = 1'b0;
   logic              is_last = 1'b0;
   logic [BN_W-1:0]   byte_num = '0;
   logic              in_ready;
   logic [OUT_W-1:0]  out_w;
   logic              buffer_full;
   logic              last_block;
   logic              f_ack = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   int blk_no = 0;

   logic [WORD_W-1:0] full_q[$];
   logic [OUT_W-1:0]  exp_q[$];
   bit                exp_last_q[$];

   keccak_padder_param #(
      .WORD_W     (WORD_W),
      .RATE_WORDS (RATE_WORDS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in          (in_w),
      .in_valid    (in_valid),
      .is_last     (is_last),
      .byte_num    (byte_num),
      .in_ready    (in_ready),
      .out         (out_w),
      .buffer_full (buffer_full),
      .last_block  (last_block),
      .f_ack       (f_ack)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WORD_W-1:0] rand_word();
      return {$urandom, $urandom};
   endfunction

   // Byte-stream model: message bytes, suffix, zero fill to a block boundary, 0x80 on the last byte.
   task automatic model_msg(input logic [WORD_W-1:0] last_w, input int bn);
      logic [7:0]       b[$];
      logic [OUT_W-1:0] v;
      int               nblk;
      foreach (full_q[i])
         for (int k = 0; k < NB; k++) b.push_back(full_q[i][WORD_W-1-8*k -: 8]);
      for (int k = 0; k < bn; k++) b.push_back(last_w[WORD_W-1-8*k -: 8]);
      b.push_back(SUFFIX_B);
      while (b.size() % RATE_BYTES != 0) b.push_back(8'h00);
      b[b.size()-1] = b[b.size()-1] | 8'h80;
      nblk = b.size() / RATE_BYTES;
      for (int blk = 0; blk < nblk; blk++) begin
         v = '0;
         for (int k = 0; k < RATE_BYTES; k++) v[OUT_W-1-8*k -: 8] = b[blk*RATE_BYTES + k];
         exp_q.push_back(v);
         exp_last_q.push_back(blk == nblk - 1);
      end
   endtask

   // Hold the full block a few cycles with junk offered on the input, then check and acknowledge it.
   task automatic consume_block();
      logic [OUT_W-1:0] ev;
      bit               el;
      int               hold;
      ev = '0;
      el = 1'b0;
      if (exp_q.size() > 0) begin
         ev = exp_q.pop_front();
         el = exp_last_q.pop_front();
      end else begin
         check_eq("spurious_block", buffer_full, 0);
      end
      hold     = $urandom_range(0, 2);
      in_valid = 1'b1;
      in_w     = rand_word();
      is_last  = 1'($urandom_range(0, 1));
      byte_num = BN_W'($urandom_range(0, NB-1));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check_eq("ready_in_full", in_ready, 0);
         check_eq("full_held", buffer_full, 1);
      end
      in_valid = 1'b0;
      is_last  = 1'b0;
      check_eq("block", out_w, ev);
      check_eq("last_block", last_block, el);
      $display("block %0d: last_block=%0d", blk_no, last_block);
      blk_no++;
      f_ack = 1'b1;
      @(posedge clk); #1;
      f_ack = 1'b0;
      check_eq("full_clr", buffer_full, 0);
      check_eq("ready_after_ack", in_ready, 1);
      check_eq("out_clr", out_w, 0);
      check_eq("last_clr", last_block, 0);
   endtask

   task automatic send_word(input logic [WORD_W-1:0] w, input bit last, input int bn);
      int guard = 0;
      while (!in_ready) begin
         if (buffer_full) consume_block();
         else begin
            @(posedge clk); #1;
         end
         guard++;
         if (guard > 200) begin
            check_eq("tmo_ready", in_ready, 1);
            $fatal(1, "in_ready wait expired");
         end
      end
      in_w     = w;
      is_last  = last;
      byte_num = BN_W'(bn);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      is_last  = 1'b0;
   endtask

   task automatic wait_block();
      int guard = 0;
      while (!buffer_full) begin
         @(posedge clk); #1;
         guard++;
         if (guard > 100) begin
            check_eq("tmo_full", buffer_full, 1);
            $fatal(1, "buffer_full wait expired");
         end
      end
      consume_block();
   endtask

   task automatic run_message(input int nfull, input logic [WORD_W-1:0] last_w, input int bn);
      full_q.delete();
      for (int i = 0; i < nfull; i++) full_q.push_back(rand_word());
      model_msg(last_w, bn);
      foreach (full_q[i]) send_word(full_q[i], 1'b0, $urandom_range(0, NB-1));
      send_word(last_w, 1'b1, bn);
      while (exp_q.size() > 0) wait_block();
   endtask

   initial begin
      logic [OUT_W-1:0]  exp_empty;
      logic [WORD_W-1:0] lw;
      exp_empty = '0;
      exp_empty[OUT_W-1 -: 8] = SUFFIX_B;
      exp_empty[7:0] = 8'h80;
      lw = 64'h1122334455667788;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out", out_w, 0);
      check_eq("rst_full", buffer_full, 0);
      check_eq("rst_last", last_block, 0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      check_eq("rst_ready", in_ready, 1);

      // Empty message: full nine cycles after acceptance
      full_q.delete();
      model_msg(rand_word(), 0);
      send_word(rand_word(), 1'b1, 0);
      for (int k = 1; k <= 8; k++) begin
         if (k < 8) begin
            @(posedge clk); #1;
         end else begin
            @(posedge clk); #1;
         end
         check_eq("empty_full_timing", buffer_full, (k == 8));
      end
      check_eq("empty_block", out_w, exp_empty);
      wait_block();

      // Eight words then a 3-byte last word in the final slot
      full_q.delete();
      for (int i = 0; i < 8; i++) full_q.push_back(rand_word());
      model_msg(lw, 3);
      foreach (full_q[i]) send_word(full_q[i], 1'b0, 0);
      send_word(lw, 1'b1, 3);
      check_eq("bn3_full_next", buffer_full, 1);
      check_eq("bn3_word8", out_w[WORD_W-1:0], {8'h11, 8'h22, 8'h33, SUFFIX_B, 24'h0, 8'h80});
      wait_block();

      // Same with a 7-byte last word: suffix and final bit share a byte
      full_q.delete();
      for (int i = 0; i < 8; i++) full_q.push_back(rand_word());
      model_msg(lw, 7);
      foreach (full_q[i]) send_word(full_q[i], 1'b0, 0);
      send_word(lw, 1'b1, 7);
      check_eq("bn7_full_next", buffer_full, 1);
      check_eq("bn7_word8", out_w[WORD_W-1:0], {56'h11223344556677, SUFFIX_B | 8'h80});
      wait_block();

      // Exact block multiple: one data block, then a suffix-only block
      run_message(9, rand_word(), 0);

      // Reset while padding (cnt=4) drops everything
      full_q.delete();
      for (int i = 0; i < 3; i++) full_q.push_back(rand_word());
      foreach (full_q[i]) send_word(full_q[i], 1'b0, 0);
      send_word(rand_word(), 1'b1, 2);
      #2 reset = 1'b0;
      #1;
      check_eq("midpad_rst_out", out_w, 0);
      check_eq("midpad_rst_full", buffer_full, 0);
      check_eq("midpad_rst_last", last_block, 0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      check_eq("midpad_rst_ready", in_ready, 1);
      full_q.delete();
      model_msg(rand_word(), 0);
      send_word(rand_word(), 1'b1, 0);
      while (!buffer_full) begin
         @(posedge clk); #1;
      end
      check_eq("after_rst_block", out_w, exp_empty);
      consume_block();

      // f_ack outside FULL is ignored
      full_q.delete();
      for (int i = 0; i < 2; i++) full_q.push_back(rand_word());
      lw = rand_word();
      model_msg(lw, 5);
      send_word(full_q[0], 1'b0, 0);
      f_ack = 1'b1;
      @(posedge clk); #1;
      f_ack = 1'b0;
      check_eq("ack_in_accept_ready", in_ready, 1);
      send_word(full_q[1], 1'b0, 0);
      send_word(lw, 1'b1, 5);
      f_ack = 1'b1;
      @(posedge clk); #1;
      f_ack = 1'b0;
      check_eq("ack_in_pad_full", buffer_full, 0);
      check_eq("ack_in_pad_ready", in_ready, 0);
      wait_block();

      // Randomized messages
      for (int m = 0; m < 25; m++) begin
         run_message($urandom_range(0, 20), rand_word(), $urandom_range(0, NB-1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
